// File: rtl/execute_writeback.sv
// Execute/write-back stage: runs one ALU op per packet (iterative shift-add MUL)
// and writes the result to data memory, with a one-entry buffer for early arrivals.
module execute_writeback #(
    parameter int DATA_WIDTH       = 8,
    parameter int DATA_MEMORY_SIZE = 64,
    localparam int AW              = $clog2(DATA_MEMORY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ready,
    input  logic [1:0]            opcode_in,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    input  logic [AW-1:0]         dst_in,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  done,
    output logic                  flag,
    output logic                  busy,
    output logic                  overrun
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WRITE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_AND = 2'b11} op_t;

    state_t                    r_state, w_stateNext;
    op_t                       r_op, r_bufOp, w_srcOp;
    logic [DATA_WIDTH-1:0]     r_a, r_b, r_bufA, r_bufB, w_srcA, w_srcB;
    logic [AW-1:0]             r_dst, r_bufDst, w_srcDst;
    logic                      r_bufValid;
    logic [2*DATA_WIDTH-1:0]   r_acc, r_mcand, w_accNext;
    logic [DATA_WIDTH-1:0]     r_mplier;
    logic [CW-1:0]             r_cnt;
    logic [DATA_WIDTH-1:0]     r_result;
    logic                      r_resFlag;
    logic                      r_memWe, r_done, r_flag, r_overrun;
    logic [AW-1:0]             r_memAddr;
    logic [DATA_WIDTH-1:0]     r_memWdata;

    logic                      w_accept, w_loadBuf, w_loadIn, w_bufWrite, w_drop, w_execDone;
    logic [DATA_WIDTH:0]       w_sum, w_diff;

    // IDLE and WRITE both accept new work; a waiting buffered op always wins.
    assign w_accept   = (r_state == S_IDLE) || (r_state == S_WRITE);
    assign w_loadBuf  = w_accept && r_bufValid;
    assign w_loadIn   = w_accept && !r_bufValid && ready;
    assign w_bufWrite = ready && ((w_accept && r_bufValid) || ((r_state == S_EXEC) && !r_bufValid));
    assign w_drop     = ready && (r_state == S_EXEC) && r_bufValid;
    assign w_execDone = (r_op != OP_MUL) || (r_cnt == CW'(DATA_WIDTH - 1));

    assign w_srcOp  = r_bufValid ? r_bufOp  : op_t'(opcode_in);
    assign w_srcA   = r_bufValid ? r_bufA   : src1;
    assign w_srcB   = r_bufValid ? r_bufB   : src2;
    assign w_srcDst = r_bufValid ? r_bufDst : dst_in;

    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
    assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (r_bufValid || ready) w_stateNext = S_EXEC;
            S_EXEC:  if (w_execDone) w_stateNext = S_WRITE;
            S_WRITE: w_stateNext = (r_bufValid || ready) ? S_EXEC : S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bufValid <= 1'b0;
            r_bufOp    <= OP_ADD;
            r_bufA     <= '0;
            r_bufB     <= '0;
            r_bufDst   <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_bufWrite) begin
                r_bufValid <= 1'b1;
                r_bufOp    <= op_t'(opcode_in);
                r_bufA     <= src1;
                r_bufB     <= src2;
                r_bufDst   <= dst_in;
            end else if (w_loadBuf) begin
                r_bufValid <= 1'b0;
            end
            if (w_drop) r_overrun <= 1'b1;
        end
    end

    // MUL walks the multiplier LSB first; result/flag track the running product
    // so the final iteration leaves the complete value behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= OP_ADD;
            r_a       <= '0;
            r_b       <= '0;
            r_dst     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_resFlag <= 1'b0;
        end else if (w_loadBuf || w_loadIn) begin
            r_op     <= w_srcOp;
            r_a      <= w_srcA;
            r_b      <= w_srcB;
            r_dst    <= w_srcDst;
            r_acc    <= '0;
            r_mcand  <= {{DATA_WIDTH{1'b0}}, w_srcA};
            r_mplier <= w_srcB;
            r_cnt    <= '0;
        end else if (r_state == S_EXEC) begin
            case (r_op)
                OP_ADD: begin
                    r_result  <= w_sum[DATA_WIDTH-1:0];
                    r_resFlag <= w_sum[DATA_WIDTH];
                end
                OP_SUB: begin
                    r_result  <= w_diff[DATA_WIDTH-1:0];
                    r_resFlag <= w_diff[DATA_WIDTH];
                end
                OP_AND: begin
                    r_result  <= r_a & r_b;
                    r_resFlag <= 1'b0;
                end
                OP_MUL: begin
                    r_acc     <= w_accNext;
                    r_mcand   <= r_mcand << 1;
                    r_mplier  <= r_mplier >> 1;
                    r_cnt     <= r_cnt + CW'(1);
                    r_result  <= w_accNext[DATA_WIDTH-1:0];
                    r_resFlag <= |w_accNext[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memWe    <= 1'b0;
            r_done     <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_flag     <= 1'b0;
        end else begin
            r_memWe <= (r_state == S_WRITE);
            r_done  <= (r_state == S_WRITE);
            if (r_state == S_WRITE) begin
                r_memAddr  <= r_dst;
                r_memWdata <= r_result;
                r_flag     <= r_resFlag;
            end
        end
    end

    assign mem_we    = r_memWe;
    assign done      = r_done;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign flag      = r_flag;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE) || r_bufValid;

endmodule

// File: tb/tb_execute_writeback.sv
// Bench for execute_writeback: directed cases then random packets, checked against
// a transaction model built from completion times and a one-deep waiting slot.
module tb_execute_writeback;
    localparam int DW  = 8;
    localparam int AW  = 6;
    localparam int MOD = 1 << DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ready;
    logic [1:0]    opcode_in;
    logic [DW-1:0] src1, src2;
    logic [AW-1:0] dst_in;
    logic          mem_we, done, flag, busy, overrun;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    always #5 clk = ~clk;

    execute_writeback #(.DATA_WIDTH(DW), .DATA_MEMORY_SIZE(64)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready), .opcode_in(opcode_in),
        .src1(src1), .src2(src2), .dst_in(dst_in),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .flag(flag), .busy(busy), .overrun(overrun)
    );

    typedef struct packed {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] dst;
    } pkt_t;

    int errors  = 0;
    int checks  = 0;
    int weCount = 0;
    int edgeNo  = 0;

    // Model: the engine owns one op until its write edge; one more may wait.
    bit            mCurValid, mBufValid;
    pkt_t          mCur, mBuf;
    int            mWriteEdge;
    logic          eWe, eFlag, eOverrun, eBusy;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eData;

    function automatic int latency(input logic [1:0] op);
        return (op == 2'b10) ? DW + 1 : 2;
    endfunction

    function automatic logic [DW:0] expectResult(input pkt_t p);
        int unsigned ai, bi, full, data;
        logic        f;
        ai = p.a;
        bi = p.b;
        case (p.op)
            2'b00: begin full = ai + bi; data = full % MOD; f = (full >= MOD); end
            2'b01: begin data = (ai + MOD - bi) % MOD; f = (ai < bi); end
            2'b10: begin full = ai * bi; data = full % MOD; f = (full >= MOD); end
            default: begin data = ai & bi; f = 1'b0; end
        endcase
        return {f, data[DW-1:0]};
    endfunction

    task automatic modelReset();
        mCurValid = 0; mBufValid = 0; mWriteEdge = 0;
        eWe = 0; eFlag = 0; eOverrun = 0; eBusy = 0; eAddr = '0; eData = '0;
    endtask

    task automatic modelEdge(input bit rdy, input pkt_t p);
        logic [DW:0] r;
        eWe = 0;
        if (mCurValid && edgeNo == mWriteEdge) begin
            r = expectResult(mCur);
            eWe = 1; eAddr = mCur.dst; eData = r[DW-1:0]; eFlag = r[DW];
            mCurValid = 0;
            if (mBufValid) begin
                mCur = mBuf; mCurValid = 1; mBufValid = 0;
                mWriteEdge = edgeNo + latency(mCur.op);
            end
        end
        if (rdy) begin
            if (!mCurValid) begin
                mCur = p; mCurValid = 1; mWriteEdge = edgeNo + latency(p.op);
            end else if (!mBufValid) begin
                mBuf = p; mBufValid = 1;
            end else begin
                eOverrun = 1;
            end
        end
        eBusy = mCurValid || mBufValid;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edgeNo);
        end
    endtask

    task automatic checkOutput();
        checkVal("mem_we",    {31'b0, mem_we},   {31'b0, eWe});
        checkVal("done",      {31'b0, done},     {31'b0, eWe});
        checkVal("mem_addr",  32'(mem_addr),     32'(eAddr));
        checkVal("mem_wdata", 32'(mem_wdata),    32'(eData));
        checkVal("flag",      {31'b0, flag},     {31'b0, eFlag});
        checkVal("busy",      {31'b0, busy},     {31'b0, eBusy});
        checkVal("overrun",   {31'b0, overrun},  {31'b0, eOverrun});
    endtask

    task automatic applyStimulus(input bit rdy, input logic [1:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [AW-1:0] dst);
        pkt_t p;
        ready = rdy; opcode_in = op; src1 = a; src2 = b; dst_in = dst;
        p.op = op; p.a = a; p.b = b; p.dst = dst;
        @(posedge clk);
        edgeNo++;
        if (rst_n) modelEdge(rdy, p);
        #1;
        if (mem_we === 1'b1) weCount++;
        checkOutput();
        ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, '0, '0, '0);
    endtask

    initial begin
        int gap;
        rst_n = 1'b0; ready = 1'b0; opcode_in = '0; src1 = '0; src2 = '0; dst_in = '0;
        modelReset();
        $display("[TB] reset phase, ready pulses must be ignored");
        applyStimulus(1'b1, 2'b00, 8'd1, 8'd2, 6'd3);
        idle(1);
        rst_n = 1'b1;
        idle(2);

        applyStimulus(1'b1, 2'b00, 8'd200, 8'd100, 6'd5);
        idle(1);
        checkVal("add_early_we", {31'b0, mem_we}, 32'd0);
        idle(1);
        checkVal("add_we", {31'b0, mem_we}, 32'd1);
        checkVal("add_addr", 32'(mem_addr), 32'd5);
        checkVal("add_data", 32'(mem_wdata), 32'd44);
        checkVal("add_flag", {31'b0, flag}, 32'd1);
        idle(2);

        applyStimulus(1'b1, 2'b01, 8'd3, 8'd5, 6'd63);
        idle(2);
        checkVal("sub_data", 32'(mem_wdata), 32'd254);
        checkVal("sub_flag", {31'b0, flag}, 32'd1);
        checkVal("sub_addr", 32'(mem_addr), 32'd63);
        idle(2);

        applyStimulus(1'b1, 2'b11, 8'hF0, 8'h3C, 6'd10);
        idle(2);
        checkVal("and_data", 32'(mem_wdata), 32'h30);
        checkVal("and_flag", {31'b0, flag}, 32'd0);
        idle(2);

        applyStimulus(1'b1, 2'b10, 8'd13, 8'd11, 6'd20);
        idle(8);
        checkVal("mul_early_we", {31'b0, mem_we}, 32'd0);
        idle(1);
        checkVal("mul_we", {31'b0, mem_we}, 32'd1);
        checkVal("mul_data", 32'(mem_wdata), 32'd143);
        checkVal("mul_flag", {31'b0, flag}, 32'd0);
        idle(2);

        applyStimulus(1'b1, 2'b10, 8'd20, 8'd20, 6'd21);
        idle(9);
        checkVal("mul2_data", 32'(mem_wdata), 32'd144);
        checkVal("mul2_flag", {31'b0, flag}, 32'd1);
        idle(2);

        $display("[TB] ready coincident with WRITE");
        applyStimulus(1'b1, 2'b00, 8'd10, 8'd20, 6'd7);
        idle(1);
        applyStimulus(1'b1, 2'b00, 8'd250, 8'd10, 6'd8);
        checkVal("b2b_first_data", 32'(mem_wdata), 32'd30);
        idle(2);
        checkVal("b2b_second_we", {31'b0, mem_we}, 32'd1);
        checkVal("b2b_second_addr", 32'(mem_addr), 32'd8);
        checkVal("b2b_second_data", 32'(mem_wdata), 32'd4);
        checkVal("b2b_overrun", {31'b0, overrun}, 32'd0);
        idle(2);

        $display("[TB] three MULs three cycles apart");
        weCount = 0;
        applyStimulus(1'b1, 2'b10, 8'd13, 8'd11, 6'd1);
        idle(2);
        applyStimulus(1'b1, 2'b10, 8'd20, 8'd20, 6'd2);
        idle(2);
        applyStimulus(1'b1, 2'b10, 8'd3, 8'd3, 6'd3);
        idle(25);
        checkVal("mul3_pulses", 32'(weCount), 32'd2);
        checkVal("mul3_overrun", {31'b0, overrun}, 32'd1);

        $display("[TB] reset in the middle of a MUL");
        applyStimulus(1'b1, 2'b10, 8'd7, 8'd9, 6'd4);
        idle(4);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput();
        checkVal("rst_addr", 32'(mem_addr), 32'd0);
        checkVal("rst_data", 32'(mem_wdata), 32'd0);
        checkVal("rst_busy", {31'b0, busy}, 32'd0);
        applyStimulus(1'b1, 2'b10, 8'd5, 8'd5, 6'd9);
        idle(1);
        rst_n = 1'b1;
        weCount = 0;
        idle(15);
        checkVal("rst_no_write", 32'(weCount), 32'd0);
        checkVal("rst_idle_busy", {31'b0, busy}, 32'd0);

        $display("[TB] random packets");
        gap = 3;
        for (int i = 0; i < 400; i++) begin
            if (gap >= 3 && $urandom_range(0, 2) == 0) begin
                applyStimulus(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                              6'($urandom_range(0, 63)));
                gap = 1;
            end else begin
                idle(1);
                gap++;
            end
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
